// File: rtl/mem_arbiter_if.sv
// Bus bundle between the Rx32 F/M stages, the arbiter and the unified memory.
// master: the arbiter; slave: the pipeline stages and memory around it.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        stall_f;
  logic        stall_m;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        mem_err;

  modport master (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata, mem_ack,
    output if_rdata, if_done,
    output d_rdata, d_done,
    output stall_f, stall_m,
    output mem_req, mem_we, mem_addr,
    output mem_wdata, mem_err
  );

  modport slave (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata, mem_ack,
    input  if_rdata, if_done,
    input  d_rdata, d_done,
    input  stall_f, stall_m,
    input  mem_req, mem_we, mem_addr,
    input  mem_wdata, mem_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises fetch and data ports onto one req/ack memory.
// Alternates on ties, one access in flight, watchdog-bounded.
module mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input logic        clk,
  input logic        reset,
  mem_arbiter_if.master bus
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] TLAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D
  } state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        err_q, err_d;
  logic        grant_d;
  logic        is_i;

  // Arbitration, latching of the granted access and completion.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wait_cnt_d   = wait_cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    err_d        = 1'b0;
    grant_d      = 1'b0;
    is_i         = (state_q == BUSY_I);
    unique case (state_q)
      IDLE: begin
        // last_grant only moves on a tie so lone requests do
        // not disturb the alternation order.
        grant_d = bus.d_req & (~bus.if_req | ~last_grant_q);
        if (bus.d_req & bus.if_req)
          last_grant_d = grant_d;
        if (grant_d) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          wait_cnt_d  = '0;
        end else if (bus.if_req) begin
          state_d     = BUSY_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = '0;
          wait_cnt_d  = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.mem_ack) begin
          state_d   = is_i ? DONE_I : DONE_D;
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            if (is_i) if_rdata_d = bus.mem_rdata;
            else      d_rdata_d  = bus.mem_rdata;
          end
        end else if (TIMEOUT != 0 &&
                     wait_cnt_q == TLAST) begin
          state_d   = is_i ? DONE_I : DONE_D;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          if (is_i) if_rdata_d = '0;
          else      d_rdata_d  = '0;
        end else if (wait_cnt_q != TMAX) begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      DONE_I, DONE_D: state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
      wait_cnt_q   <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      err_q        <= err_d;
    end
  end

  assign bus.if_done   = (state_q == DONE_I);
  assign bus.d_done    = (state_q == DONE_D);
  assign bus.stall_f   = bus.if_req & ~bus.if_done;
  assign bus.stall_m   = bus.d_req & ~bus.d_done;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_err   = err_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one unified single-port memory between the Rx32 instruction-fetch stage (F) and the memory-access stage (M). The pipeline keeps separate instruction and data ports; this block serialises them onto one variable-latency memory with a req/ack handshake. It returns per-requester completion pulses and stall signals, and bounds every access with a watchdog timeout.

## Interface
- `TIMEOUT`, 16: max BUSY cycles without `mem_ack` before abort; 0 disables the watchdog.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch request, held until `if_done`.
- `if_addr`  in  32  fetch address (PCF).
- `if_rdata`  out  32  fetched instruction; registered, valid when `if_done`=1.
- `if_done`  out  1  one-cycle completion pulse for fetch.
- `d_req`  in  1  data request, held until `d_done`.
- `d_we`  in  1  1 = write, 0 = read (MemWriteM).
- `d_addr`  in  32  data address (ALUOutM).
- `d_wdata`  in  32  store data (WriteDataM).
- `d_rdata`  out  32  load data (ReadDataM); registered.
- `d_done`  out  1  one-cycle completion pulse for data.
- `stall_f`  out  1  `if_req & ~if_done`; combinational.
- `stall_m`  out  1  `d_req & ~d_done`; combinational.
- `mem_req`  out  1  memory request; registered.
- `mem_we`  out  1  memory write enable; registered.
- `mem_addr`  out  32  memory address; registered.
- `mem_wdata`  out  32  memory write data; registered.
- `mem_rdata`  in  32  memory read data; valid when `mem_ack`=1.
- `mem_ack`  in  1  memory completion; may arrive in the first BUSY cycle.
- `mem_err`  out  1  one-cycle pulse, coincident with `*_done`, on a watchdog abort.

## Operation
- States:
  - IDLE: `mem_req`=0.
  - BUSY_I / BUSY_D: `mem_req`=1.
  - DONE_I / DONE_D: `if_done` or `d_done`=1 respectively.
- IDLE arbitration, sampled at the clock edge:
  - Only `d_req` → BUSY_D. Only `if_req` → BUSY_I. Neither → stay IDLE.
  - Both asserted → grant the side not granted last (`last_grant`), then update `last_grant`.
- On entering BUSY:
  - Latch `mem_addr`, `mem_we`, `mem_wdata` from the granted requester.
  - Fetch forces `mem_we`=0.
  - These outputs stay stable for the whole BUSY period.
- BUSY with `mem_ack`=1 at an edge → DONE_x.
  - On a read, `mem_rdata` is captured into `if_rdata` or `d_rdata`.
  - On a write, `d_rdata` is unchanged.
- Watchdog:
  - `wait_cnt` counts BUSY cycles.
  - If `TIMEOUT`≠0 and the TIMEOUT-th consecutive BUSY cycle ends without ack → DONE_x with `mem_err`=1 and the read register loaded with 0x00000000.
  - An ack in that same cycle wins: normal completion, no error.
- DONE_x lasts exactly one cycle, then → IDLE.
  - Requests are ignored in DONE, because the requester's `req`/addr may still show the old transaction at that edge.
- Each side's `*_rdata` holds its value until that side's next read completion.

## Timing
- Reset: state=IDLE, `last_grant`=I (so the first tie goes to D), `wait_cnt`=0. All outputs 0, including `if_rdata`, `d_rdata`, `mem_*`.
- Reset mid-transaction: abandon the access. `mem_req`=0 from the cycle after the reset edge; no `*_done` and no `mem_err` for the aborted access.
- Latency with zero-wait memory (ack in first BUSY cycle):
  - req sampled at edge 0 → BUSY cycle 1 → DONE cycle 2.
  - `*_done` is high 2 cycles after req is first seen.
  - With N extra wait cycles: 2+N.
- Issue rate: minimum 3 cycles per access per memory port, covering IDLE, BUSY and DONE.
- `stall_f`/`stall_m` fall in the same cycle `*_done` rises, so the pipeline advances at the end of the DONE cycle.
- `mem_err` is asserted only in a DONE cycle and never without a `*_done`.
- `wait_cnt` width: `$clog2(TIMEOUT+1)`; cleared on entering BUSY, saturates, never wraps.

## Test plan
- Reset, then `if_req`=1, `if_addr`=0x00000004, memory acks in the first BUSY cycle with 0x20080005 → `mem_addr`=0x4, `mem_we`=0, `if_done` 2 cycles later, `if_rdata`=0x20080005, `stall_f` low only in the done cycle.
- `d_req`=1 and `if_req`=1 asserted in the same cycle after reset → D granted first, then I.
  - Next simultaneous pair → I first (alternation).
  - Memory never sees a grant while `mem_req`=1.
- Store: `d_we`=1, `d_addr`=0x40, `d_wdata`=0xDEADBEEF, ack after 3 wait cycles:
  - `mem_we`/`mem_addr`/`mem_wdata` stable for 4 BUSY cycles.
  - `d_done` at cycle 5.
  - `d_rdata` unchanged from its previous value.
- `TIMEOUT`=4, memory never acks → `d_done` and `mem_err` both pulse after 4 BUSY cycles, `d_rdata`=0. Repeat with ack in the 4th BUSY cycle → no `mem_err`.
- `reset` asserted during the 2nd BUSY cycle of a fetch:
  - `mem_req`=0 next cycle, no `if_done`, all outputs 0.
  - A fresh request afterwards completes normally.
